// File: rtl/fc_argmax_classifier_pkg.sv
// Shared constants, types and helpers for the CNN argmax output stage.
package cnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 4;

  typedef logic signed [DATA_W-1:0] logit_t;
  typedef logic        [ADDR_W-1:0] class_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } argmax_state_e;

  // Most negative logit; also the "empty" value of the runner-up slot.
  localparam logit_t LOGIT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Largest reportable margin.
  localparam logic [DATA_W-1:0] MARGIN_SAT = {1'b0, {(DATA_W-1){1'b1}}};

  // Address of the final logit in L2.
  localparam class_idx_t LAST_IDX = class_idx_t'(NUM_CLASSES - 1);

  // Difference hi - lo evaluated one bit wider so it cannot wrap, then clamped.
  function automatic logic [DATA_W-1:0] sat_margin(input logit_t hi, input logit_t lo);
    logic signed [DATA_W:0] diff;
    diff = $signed({hi[DATA_W-1], hi}) - $signed({lo[DATA_W-1], lo});
    if (diff > $signed({2'b00, {(DATA_W-1){1'b1}}})) begin
      return MARGIN_SAT;
    end else begin
      return diff[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fc_argmax_classifier_top2_tracker.sv
// Streaming top-2 tracker: keeps the largest and second-largest logit seen
// since the last clear, together with their class indices. Ties keep the
// earlier (lower) index in the higher rank.
module top2_tracker
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       in_valid,
  input  logit_t     in_data,
  input  class_idx_t in_idx,
  output logit_t     best_val,
  output class_idx_t best_idx,
  output logit_t     sec_val,
  output class_idx_t sec_idx
);

  logit_t     best_val_q, best_val_d;
  class_idx_t best_idx_q, best_idx_d;
  logit_t     sec_val_q,  sec_val_d;
  class_idx_t sec_idx_q,  sec_idx_d;
  // Empty flags let the first beat always take "best" and the first losing
  // beat always take "second", even when that beat equals LOGIT_MIN.
  logic       best_empty_q, best_empty_d;
  logic       sec_empty_q,  sec_empty_d;

  // Compare each valid beat against the current ranking and shift it in.
  always_comb begin
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    sec_val_d    = sec_val_q;
    sec_idx_d    = sec_idx_q;
    best_empty_d = best_empty_q;
    sec_empty_d  = sec_empty_q;
    if (clr) begin
      best_val_d   = LOGIT_MIN;
      best_idx_d   = '0;
      sec_val_d    = LOGIT_MIN;
      sec_idx_d    = '0;
      best_empty_d = 1'b1;
      sec_empty_d  = 1'b1;
    end else if (in_valid) begin
      if (best_empty_q) begin
        best_val_d   = in_data;
        best_idx_d   = in_idx;
        best_empty_d = 1'b0;
      end else if (in_data > best_val_q) begin
        sec_val_d   = best_val_q;
        sec_idx_d   = best_idx_q;
        sec_empty_d = 1'b0;
        best_val_d  = in_data;
        best_idx_d  = in_idx;
      end else if (sec_empty_q || (in_data > sec_val_q)) begin
        sec_val_d   = in_data;
        sec_idx_d   = in_idx;
        sec_empty_d = 1'b0;
      end else begin
        sec_empty_d = sec_empty_q;
      end
    end else begin
      best_empty_d = best_empty_q;
    end
  end

  // Ranking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_val_q   <= LOGIT_MIN;
      best_idx_q   <= '0;
      sec_val_q    <= LOGIT_MIN;
      sec_idx_q    <= '0;
      best_empty_q <= 1'b1;
      sec_empty_q  <= 1'b1;
    end else begin
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      sec_val_q    <= sec_val_d;
      sec_idx_q    <= sec_idx_d;
      best_empty_q <= best_empty_d;
      sec_empty_q  <= sec_empty_d;
    end
  end

  assign best_val = best_val_q;
  assign best_idx = best_idx_q;
  assign sec_val  = sec_val_q;
  assign sec_idx  = sec_idx_q;

endmodule

// File: rtl/fc_argmax_classifier.sv
// Argmax output stage: on conv_done, streams the NUM_CLASSES logits out of L2,
// ranks the top two, and holds class ID, score and margin for the host.
module fc_argmax_classifier
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              conv_done,
  output logic              oe_L2,
  output logic [ADDR_W-1:0] raddr_L2,
  input  logic [DATA_W-1:0] r_data_L2,
  output logic              busy,
  output logic              result_valid,
  output logic [ADDR_W-1:0] class_id,
  output logic [DATA_W-1:0] top_score,
  output logic [ADDR_W-1:0] second_id,
  output logic [DATA_W-1:0] margin,
  output logic              overrun
);

  // With a single class there is no runner-up; margin reports full scale.
  localparam logic SINGLE_CLASS = 1'(NUM_CLASSES == 1);

  argmax_state_e     state_q, state_d;
  class_idx_t        raddr_q, raddr_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              overrun_q, overrun_d;
  class_idx_t        class_id_q, class_id_d;
  logit_t            top_score_q, top_score_d;
  class_idx_t        second_id_q, second_id_d;
  logic [DATA_W-1:0] margin_q, margin_d;
  // Read-return pipeline: beat valid and the address it belongs to.
  logic              rd_vld_q, rd_vld_d;
  class_idx_t        rd_idx_q, rd_idx_d;

  logic              trk_clr_s;
  logit_t            rd_data_s;
  logit_t            best_val_s, sec_val_s;
  class_idx_t        best_idx_s, sec_idx_s;

  assign rd_data_s = logit_t'(r_data_L2);

  top2_tracker u_top2_tracker (
    .clk      (clk),
    .reset    (reset),
    .clr      (trk_clr_s),
    .in_valid (rd_vld_q),
    .in_data  (rd_data_s),
    .in_idx   (rd_idx_q),
    .best_val (best_val_s),
    .best_idx (best_idx_s),
    .sec_val  (sec_val_s),
    .sec_idx  (sec_idx_s)
  );

  // Sequencer: next state, L2 read stream, and result capture.
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    rv_d        = rv_q;
    class_id_d  = class_id_q;
    top_score_d = top_score_q;
    second_id_d = second_id_q;
    margin_d    = margin_q;
    trk_clr_s   = 1'b0;
    rd_vld_d    = oe_q;
    rd_idx_d    = raddr_q;

    // A start request while a run is in flight is dropped but remembered.
    if (conv_done && busy_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (conv_done) begin
          state_d   = READ;
          raddr_d   = '0;
          oe_d      = 1'b1;
          busy_d    = 1'b1;
          rv_d      = 1'b0;
          trk_clr_s = 1'b1;
        end else begin
          oe_d = 1'b0;
        end
      end
      READ: begin
        if (raddr_q == LAST_IDX) begin
          state_d = DRAIN;
          oe_d    = 1'b0;
        end else begin
          raddr_d = raddr_q + class_idx_t'(1);
        end
      end
      DRAIN: begin
        // The last beat reaches the tracker on this edge.
        state_d = DONE;
      end
      DONE: begin
        class_id_d  = best_idx_s;
        top_score_d = best_val_s;
        second_id_d = sec_idx_s;
        margin_d    = SINGLE_CLASS ? MARGIN_SAT : sat_margin(best_val_s, sec_val_s);
        rv_d        = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All sequencer, pipeline and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      raddr_q     <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      rv_q        <= 1'b0;
      overrun_q   <= 1'b0;
      class_id_q  <= '0;
      top_score_q <= '0;
      second_id_q <= '0;
      margin_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      rv_q        <= rv_d;
      overrun_q   <= overrun_d;
      class_id_q  <= class_id_d;
      top_score_q <= top_score_d;
      second_id_q <= second_id_d;
      margin_q    <= margin_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  assign oe_L2        = oe_q;
  assign raddr_L2     = raddr_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign overrun      = overrun_q;
  assign class_id     = class_id_q;
  assign top_score    = top_score_q;
  assign second_id    = second_id_q;
  assign margin       = margin_q;

endmodule
